// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with registered or first-word-fall-through output
`timescale 1ns/1ps
module fifo_param #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] buff_in,
  input  logic [ADDR_WIDTH:0]   umb_almost_full,
  input  logic [ADDR_WIDTH:0]   umb_almost_empty,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] buff_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow_err;
  logic                  r_underflow_err;
  logic                  w_rd_acc;
  logic                  w_wr_acc;

  assign fifo_full    = (r_count == C_DEPTH);
  assign fifo_empty   = (r_count == '0);
  assign almost_full  = (r_count >= umb_almost_full);
  assign almost_empty = (r_count <= umb_almost_empty);
  assign data_count   = r_count;
  assign overflow_err  = r_overflow_err;
  assign underflow_err = r_underflow_err;

  // A pop in the same cycle frees a slot, so a write at full is still accepted.
  assign w_rd_acc = read && !fifo_empty;
  assign w_wr_acc = write && (!fifo_full || w_rd_acc);

  always_ff @(posedge clk) begin
    if (reset_L && w_wr_acc) begin
      r_mem[r_wr_ptr] <= buff_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
      // Setting has priority over clearing when both happen in one cycle.
      if (write && !w_wr_acc) r_overflow_err <= 1'b1;
      else if (clear_err)     r_overflow_err <= 1'b0;
      if (read && fifo_empty) r_underflow_err <= 1'b1;
      else if (clear_err)     r_underflow_err <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign buff_out  = fifo_empty ? '0 : r_mem[r_rd_ptr];
      assign valid_out = !fifo_empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_buff_out;
      logic                  r_valid_out;
      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
          r_buff_out  <= '0;
          r_valid_out <= 1'b0;
        end else begin
          r_valid_out <= w_rd_acc;
          if (w_rd_acc) r_buff_out <= r_mem[r_rd_ptr];
        end
      end
      assign buff_out  = r_buff_out;
      assign valid_out = r_valid_out;
    end
  endgenerate

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Next-generation parametrised synchronous FIFO for the data path. Replaces the fixed 4-bit queue.
- Width and depth are parameters, with a selectable output mode: registered-read or first-word-fall-through.
- Adds sticky overflow/underflow error flags and explicit output-valid.
- Keeps programmable almost-full/almost-empty thresholds and data_count, so existing probador/bench structure carries over.

Parameters:
DATA_WIDTH, 6, width of buff_in/buff_out
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 8)
FWFT, 0, 0 = registered read (1-cycle latency), 1 = first-word-fall-through

Ports:
clk  input  1  rising-edge clock, sole clock domain
reset_L  input  1  asynchronous, active-low reset
write  input  1  push request
read  input  1  pop request
buff_in  input  DATA_WIDTH  push data
umb_almost_full  input  ADDR_WIDTH+1  almost-full threshold (count units)
umb_almost_empty  input  ADDR_WIDTH+1  almost-empty threshold (count units)
clear_err  input  1  clears sticky error flags
buff_out  output  DATA_WIDTH  pop data
valid_out  output  1  buff_out holds valid data
data_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
fifo_full  output  1  data_count == DEPTH
fifo_empty  output  1  data_count == 0
almost_full  output  1  data_count >= umb_almost_full
almost_empty  output  1  data_count <= umb_almost_empty
overflow_err  output  1  sticky: write attempted but rejected
underflow_err  output  1  sticky: read attempted while empty

Behaviour:
- Reset (reset_L low, asynchronous, any time):
  - wr_ptr, rd_ptr and count go to 0.
  - buff_out=0, valid_out=0, overflow_err=0, underflow_err=0.
  - fifo_empty=1, almost_empty=1 (threshold >= 0), fifo_full=0; almost_full = (umb_almost_full==0).
  - Memory array is not reset. Contents are logically discarded mid-operation.
  - Release is synchronous to the next rising edge.
- Acceptance, evaluated on pre-edge state:
  - rd_acc = read && !fifo_empty.
  - wr_acc = write && (!fifo_full || rd_acc).
- Updates on an edge:
  - On wr_acc: mem[wr_ptr] <= buff_in and wr_ptr++.
  - On rd_acc: rd_ptr++.
  - Pointers are ADDR_WIDTH bits and wrap modulo DEPTH.
  - count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- Full + read + write: both accepted, count stays DEPTH, no overflow.
- Empty + read + write: write accepted, read rejected, count -> 1, underflow_err set.
- Flags:
  - fifo_full, fifo_empty, almost_full and almost_empty are combinational from registered count and current thresholds.
  - Thresholds may change any cycle; they are unsigned compares.
- FWFT=0:
  - On rd_acc, buff_out <= mem[rd_ptr] at that edge and valid_out=1 for exactly the following cycle.
  - Otherwise valid_out <= 0 and buff_out holds its last value.
  - Read latency is 1 cycle.
- FWFT=1:
  - buff_out = mem[rd_ptr] when !fifo_empty, else 0. valid_out = !fifo_empty.
  - read acts as acknowledge/pop.
  - A write into an empty FIFO is visible on buff_out the cycle after the write edge (zero-cycle read latency, one-cycle write-to-read latency).
- Errors:
  - overflow_err set on an edge where write && !wr_acc.
  - underflow_err set on an edge where read && fifo_empty.
  - Both are sticky until clear_err is sampled high. Set and clear in the same cycle: set wins.
  - Errors never alter pointers or count.
- Data ordering is strict FIFO. No data is lost except on rejected writes.

Test Plan:
- Reset/idle: assert reset_L=0 mid-stream with count=5 -> all outputs immediately 0 / empty=1; after release, read gives underflow_err=1 and count stays 0.
- Fill/drain, FWFT=0, DEPTH=8, umb_af=6, umb_ae=2:
  - Write 0x01..0x08 on 8 consecutive cycles -> count 1..8; almost_empty drops after the 3rd write, almost_full rises after the 6th, fifo_full=1 after the 8th.
  - Then read 8 cycles -> buff_out 0x01..0x08, each with valid_out=1 one cycle after its read.
- Overflow: at full, a write without read -> count stays 8, overflow_err=1 and held. Pulse clear_err -> 0. clear_err together with a new rejected write -> stays 1.
- Simultaneous ops:
  - At full, read+write 0x2A -> count 8, no error, 0x2A emerges 8 reads later.
  - At empty, read+write 0x15 -> count 1, underflow_err=1.
- Wrap-around: 20 cycles of continuous read+write at count=3 with an incrementing pattern -> output sequence exact, count constant 3, pointers wrapped twice.
- FWFT=1 instance: write 0x33 to empty -> next cycle buff_out=0x33, valid_out=1 with no read. Read -> following cycle valid_out=0, buff_out=0.
